// File: rtl/alu_seq_if.sv
// Start/done request bus between the issuing stage and the alu_seq execute unit.
// The master drives the operation; the slave returns the registered result.
interface alu_seq_if #(
   parameter int unsigned XLEN = 32
);
   logic            start;
   logic [3:0]      alu_ctrl;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   logic            zero;

   modport master (
      output start, alu_ctrl, a, b,
      input  busy, done, result, zero
   );

   modport slave (
      input  start, alu_ctrl, a, b,
      output busy, done, result, zero
   );
endinterface

// File: rtl/alu_seq.sv
// RV32I execute unit: single-cycle logic/arith/compare ops and a
// 1-bit-per-cycle iterative shifter, with a registered result under start/done.
module alu_seq #(
   parameter int unsigned XLEN = 32
) (
   input logic     clk,
   input logic     rst,
   alu_seq_if.slave bus
);
   localparam int unsigned SHAMT_W = 5;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SLTU = 4'b1000;
   localparam logic [3:0] OP_XOR  = 4'b1001;
   localparam logic [3:0] OP_SLL  = 4'b1010;
   localparam logic [3:0] OP_SRL  = 4'b1011;
   localparam logic [3:0] OP_SRA  = 4'b1100;

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   state_t             r_state;
   logic [3:0]         r_op;
   logic [XLEN-1:0]    r_acc;
   logic [SHAMT_W-1:0] r_cnt;
   logic               r_busy;
   logic               r_done;
   logic [XLEN-1:0]    r_result;
   logic               r_zero;

   logic               w_is_shift;
   logic [SHAMT_W-1:0] w_shamt;
   logic [XLEN-1:0]    w_alu_res;
   logic [XLEN-1:0]    w_shift_next;

   assign w_is_shift = (bus.alu_ctrl == OP_SLL) || (bus.alu_ctrl == OP_SRL) ||
                       (bus.alu_ctrl == OP_SRA);
   assign w_shamt    = bus.b[SHAMT_W-1:0];

   // Single-cycle result; shifts only take this path when shamt is zero, so they pass a through.
   always_comb begin
      w_alu_res = '0;
      case (bus.alu_ctrl)
         OP_AND:  w_alu_res = bus.a & bus.b;
         OP_OR:   w_alu_res = bus.a | bus.b;
         OP_ADD:  w_alu_res = bus.a + bus.b;
         OP_SUB:  w_alu_res = bus.a - bus.b;
         OP_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
         OP_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
         OP_XOR:  w_alu_res = bus.a ^ bus.b;
         OP_SLL,
         OP_SRL,
         OP_SRA:  w_alu_res = bus.a;
         default: w_alu_res = '0;
      endcase
   end

   // One step of the iterative shifter, driven by the latched opcode.
   always_comb begin
      w_shift_next = r_acc;
      case (r_op)
         OP_SLL:  w_shift_next = {r_acc[XLEN-2:0], 1'b0};
         OP_SRL:  w_shift_next = {1'b0, r_acc[XLEN-1:1]};
         OP_SRA:  w_shift_next = {r_acc[XLEN-1], r_acc[XLEN-1:1]};
         default: w_shift_next = r_acc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_op     <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
         r_zero   <= 1'b1;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_op <= bus.alu_ctrl;
                  if (w_is_shift && (w_shamt != '0)) begin
                     r_acc   <= bus.a;
                     r_cnt   <= w_shamt;
                     r_busy  <= 1'b1;
                     r_state <= S_SHIFT;
                  end else begin
                     r_result <= w_alu_res;
                     r_zero   <= (w_alu_res == '0);
                     r_done   <= 1'b1;
                  end
               end
            end
            S_SHIFT: begin
               r_acc <= w_shift_next;
               r_cnt <= r_cnt - SHAMT_W'(1);
               if (r_cnt == SHAMT_W'(1)) begin
                  r_result <= w_shift_next;
                  r_zero   <= (w_shift_next == '0);
                  r_done   <= 1'b1;
                  r_busy   <= 1'b0;
                  r_state  <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
   assign bus.result = r_result;
   assign bus.zero   = r_zero;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expected result and done cycle are queued at issue
// and checked when done pulses; directed cases plus a short random sweep.
module tb_alu_seq;
   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SLTU = 4'b1000;
   localparam logic [3:0] OP_XOR  = 4'b1001;
   localparam logic [3:0] OP_SLL  = 4'b1010;
   localparam logic [3:0] OP_SRL  = 4'b1011;
   localparam logic [3:0] OP_SRA  = 4'b1100;

   typedef struct {
      logic [31:0] res;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   exp_t q[$];

   alu_seq_if #(.XLEN(32)) bus ();

   alu_seq #(.XLEN(32)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic signed [31:0] sa;
      logic [4:0]         sh;
      sa = a;
      sh = b[4:0];
      case (op)
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_SLT:  return (sa < $signed(b)) ? 32'd1 : 32'd0;
         OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
         OP_XOR:  return a ^ b;
         OP_SLL:  return a << sh;
         OP_SRL:  return a >> sh;
         OP_SRA:  return 32'(sa >>> sh);
         default: return 32'd0;
      endcase
   endfunction

   function automatic int shift_len(input logic [3:0] op, input logic [31:0] b);
      if (op == OP_SLL || op == OP_SRL || op == OP_SRA) return int'(b[4:0]);
      return 0;
   endfunction

   // Drive one request at a negedge; returns at the following negedge with start low.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
      exp_t e;
      bus.start    = 1'b1;
      bus.alu_ctrl = op;
      bus.a        = a;
      bus.b        = b;
      e.res = exp;
      e.cyc = cyc + 1 + shift_len(op, b);
      q.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic issue_shift_busy(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] exp);
      int n;
      n = shift_len(op, b);
      issue(op, a, b, exp);
      for (int i = 0; i < n; i++) begin
         chk("busy_during_shift", 32'(bus.busy), 32'd1);
         @(negedge clk);
      end
      chk("busy_at_done", 32'(bus.busy), 32'd0);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((q.size() != 0 || bus.busy) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", 32'(q.size()), 32'd0);
      @(negedge clk);
   endtask

   // Scoreboard: every done pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      if (bus.done) begin
         exp_t e;
         chk("done_with_busy", 32'(bus.busy), 32'd0);
         if (q.size() == 0) begin
            chk("spurious_done", 32'(bus.done), 32'd0);
         end else begin
            e = q.pop_front();
            chk("result", bus.result, e.res);
            chk("zero", 32'(bus.zero), 32'(e.res == 32'd0));
            chk("done_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      logic [3:0]  ops [10];
      logic [3:0]  op;
      logic [31:0] ra, rb;
      ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_XOR, OP_SLL, OP_SRL, OP_SRA};

      bus.start    = 1'b0;
      bus.alu_ctrl = 4'd0;
      bus.a        = 32'd0;
      bus.b        = 32'd0;
      rst          = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_result", bus.result, 32'd0);
      chk("rst_zero", 32'(bus.zero), 32'd1);
      rst = 1'b0;
      @(negedge clk);

      issue(OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
      wait_idle();
      issue(OP_SUB, 32'd5, 32'd5, 32'd0);
      wait_idle();

      issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
      issue(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
      wait_idle();

      issue_shift_busy(OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
      wait_idle();
      issue_shift_busy(OP_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000);
      wait_idle();
      issue_shift_busy(OP_SLL, 32'd1, 32'h23, 32'd8);
      wait_idle();
      issue(OP_SLL, 32'h0000_1234, 32'h20, 32'h0000_1234);
      wait_idle();

      // A start during a long shift must be dropped.
      issue(OP_SLL, 32'd1, 32'd31, 32'h8000_0000);
      repeat (5) @(negedge clk);
      bus.start    = 1'b1;
      bus.alu_ctrl = OP_ADD;
      bus.a        = 32'd1;
      bus.b        = 32'd1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_idle();

      // Reset partway through an SRL aborts it without a done.
      issue(OP_SRL, 32'hF000_0000, 32'd10, 32'd0);
      @(negedge clk);
      q.delete();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_result", bus.result, 32'd0);
      chk("abort_zero", 32'(bus.zero), 32'd1);
      repeat (15) @(negedge clk);

      // Reset and start together: start is dropped.
      issue(OP_OR, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF);
      wait_idle();
      rst          = 1'b1;
      bus.start    = 1'b1;
      bus.alu_ctrl = OP_ADD;
      bus.a        = 32'd3;
      bus.b        = 32'd4;
      @(negedge clk);
      rst       = 1'b0;
      bus.start = 1'b0;
      chk("rst_start_done", 32'(bus.done), 32'd0);
      chk("rst_start_result", bus.result, 32'd0);
      @(negedge clk);
      chk("rst_start_dropped", 32'(bus.done), 32'd0);

      issue(OP_XOR, 32'h0000_FF00, 32'h0000_0FF0, 32'h0000_F0F0);
      issue(4'hF, 32'h0000_0012, 32'h0000_0034, 32'd0);
      issue(OP_AND, 32'hFFFF_0F0F, 32'h0F0F_FFFF, 32'h0F0F_0F0F);
      wait_idle();

      for (int i = 0; i < 40; i++) begin
         op = ops[$urandom_range(0, 9)];
         ra = $urandom;
         rb = $urandom;
         if (i % 7 == 0) rb = ra;
         issue(op, ra, rb, ref_alu(op, ra, rb));
         if (shift_len(op, rb) != 0 || (i % 3 == 0)) wait_idle();
      end
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
